// File: rtl/ftl_pkg.sv
// rtl/ftl_pkg.sv - shared types and constants for the FTL address translator
package ftl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    ALLOC  = 2'd2,
    RESP   = 2'd3
  } ftl_state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // L2P entry width is fixed here; the top checks its NUM_PPAGES agrees.
  localparam int NUM_PPAGES_DEF = 512;
  localparam int PPN_W          = $clog2(NUM_PPAGES_DEF);

  typedef struct packed {
    logic             v;
    logic [PPN_W-1:0] ppn;
  } l2p_entry_t;

endpackage

// File: rtl/ftl_cache_tags.sv
// rtl/ftl_cache_tags.sv - direct-mapped tag array tracking recently touched logical pages
module ftl_cache_tags #(
  parameter int LPN_W       = 8,
  parameter int CACHE_LINES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [LPN_W-1:0] lpn_i,
  input  logic             install_i,
  output logic             hit_o
);

  localparam int IDX_W = $clog2(CACHE_LINES);

  logic [LPN_W-1:0]       tag_mem [CACHE_LINES];
  logic [CACHE_LINES-1:0] tag_v_q;
  logic [CACHE_LINES-1:0] tag_v_d;
  logic [IDX_W-1:0]       idx;

  assign idx   = lpn_i[IDX_W-1:0];
  assign hit_o = tag_v_q[idx] && (tag_mem[idx] == lpn_i);

  always_comb begin
    tag_v_d = tag_v_q;
    if (install_i) begin
      tag_v_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_v_q <= '0;
    end else begin
      tag_v_q <= tag_v_d;
    end
  end

  // Tag values carry no reset; an install coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (install_i && !rst_i) begin
      tag_mem[idx] <= lpn_i;
    end
  end

endmodule

// File: rtl/ftl_addr_translator.sv
// rtl/ftl_addr_translator.sv - logical-to-physical page translator with log-structured write allocation
module ftl_addr_translator
  import ftl_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int PAGE_OFFSET_BITS = 12,
  parameter int NUM_LPAGES       = 256,
  parameter int NUM_PPAGES       = 512,
  parameter int CACHE_LINES      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  addr_valid,
  input  logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_new_address,
  output logic                  addr_resp,
  output logic                  cache_hit,
  output logic                  busy_o,
  output logic                  wrap_o,
  output logic                  range_err_o
);

  localparam int LPN_W  = $clog2(NUM_LPAGES);
  localparam int IDX_W  = $clog2(CACHE_LINES);
  localparam int HI_LSB = PAGE_OFFSET_BITS + LPN_W;

  if (NUM_PPAGES < NUM_LPAGES) begin : g_err_ppages
    $error("NUM_PPAGES must be >= NUM_LPAGES");
  end
  if ($clog2(NUM_PPAGES) != PPN_W) begin : g_err_ppn_w
    $error("NUM_PPAGES does not match the L2P entry width");
  end
  if ((CACHE_LINES & (CACHE_LINES - 1)) != 0 || IDX_W > LPN_W) begin : g_err_lines
    $error("CACHE_LINES must be a power of 2 no larger than NUM_LPAGES");
  end
  if (PPN_W + PAGE_OFFSET_BITS > ADDR_WIDTH || HI_LSB > ADDR_WIDTH) begin : g_err_addr
    $error("ADDR_WIDTH too narrow for page geometry");
  end

  ftl_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic [PPN_W-1:0]        free_ptr_q, free_ptr_d;
  logic                    hit_q, hit_d;
  logic [ADDR_WIDTH-1:0]   new_addr_q, new_addr_d;
  logic                    resp_q, resp_d;
  logic                    wrap_q, wrap_d;
  logic                    range_err_q, range_err_d;
  logic [NUM_LPAGES-1:0]   l2p_v_q, l2p_v_d;

  logic [PPN_W-1:0]        l2p_ppn_mem [NUM_LPAGES];
  l2p_entry_t              rd_entry;
  logic [LPN_W-1:0]        lpn;
  logic [PAGE_OFFSET_BITS-1:0] off;
  logic                    out_of_range;
  logic                    tag_hit;
  logic                    tag_install;
  logic                    l2p_we;

  assign lpn = addr_q[PAGE_OFFSET_BITS +: LPN_W];
  assign off = addr_q[PAGE_OFFSET_BITS-1:0];

  // Covers both stray high address bits and non-power-of-2 table sizes.
  assign out_of_range = ((addr_q >> HI_LSB) != '0) ||
                        ({1'b0, lpn} >= (LPN_W+1)'(NUM_LPAGES));

  assign rd_entry = '{v: l2p_v_q[lpn], ppn: l2p_ppn_mem[lpn]};

  ftl_cache_tags #(
    .LPN_W       (LPN_W),
    .CACHE_LINES (CACHE_LINES)
  ) u_tags (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .lpn_i     (lpn),
    .install_i (tag_install),
    .hit_o     (tag_hit)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    free_ptr_d  = free_ptr_q;
    hit_d       = hit_q;
    new_addr_d  = new_addr_q;
    resp_d      = resp_q;
    wrap_d      = wrap_q;
    range_err_d = range_err_q;
    tag_install = 1'b0;
    l2p_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        resp_d = 1'b0;
        if (addr_valid) begin
          addr_d  = mem_address;
          rw_d    = mem_rw;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        hit_d = tag_hit;
        if (out_of_range) begin
          new_addr_d  = addr_q;
          hit_d       = 1'b0;
          range_err_d = 1'b1;
          state_d     = RESP;
        end else if (rw_q == MEM_WRITE) begin
          state_d = ALLOC;
        end else begin
          if (rd_entry.v) begin
            new_addr_d = ADDR_WIDTH'({rd_entry.ppn, off});
          end else begin
            new_addr_d = ADDR_WIDTH'({lpn, off});
          end
          tag_install = 1'b1;
          state_d     = RESP;
        end
      end

      ALLOC: begin
        l2p_we      = 1'b1;
        tag_install = 1'b1;
        new_addr_d  = ADDR_WIDTH'({free_ptr_q, off});
        if (free_ptr_q == PPN_W'(NUM_PPAGES - 1)) begin
          free_ptr_d = '0;
          wrap_d     = 1'b1;
        end else begin
          free_ptr_d = free_ptr_q + 1'b1;
        end
        state_d = RESP;
      end

      RESP: begin
        // Response is held at least one cycle before a low valid can release it.
        if (resp_q && !addr_valid) begin
          resp_d  = 1'b0;
          state_d = IDLE;
        end else begin
          resp_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    l2p_v_d = l2p_v_q;
    if (l2p_we) begin
      l2p_v_d[lpn] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rw_q        <= MEM_READ;
      free_ptr_q  <= '0;
      hit_q       <= 1'b0;
      new_addr_q  <= '0;
      resp_q      <= 1'b0;
      wrap_q      <= 1'b0;
      range_err_q <= 1'b0;
      l2p_v_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      free_ptr_q  <= free_ptr_d;
      hit_q       <= hit_d;
      new_addr_q  <= new_addr_d;
      resp_q      <= resp_d;
      wrap_q      <= wrap_d;
      range_err_q <= range_err_d;
      l2p_v_q     <= l2p_v_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (l2p_we && !rst_i) begin
      l2p_ppn_mem[lpn] <= free_ptr_q;
    end
  end

  assign mem_new_address = new_addr_q;
  assign addr_resp       = resp_q;
  assign cache_hit       = hit_q;
  assign busy_o          = (state_q != IDLE);
  assign wrap_o          = wrap_q;
  assign range_err_o     = range_err_q;

endmodule

// File: tb/tb_ftl_addr_translator.sv
// tb/tb_ftl_addr_translator.sv - self-checking bench for the FTL address translator
`timescale 1ns/1ps
module tb_ftl_addr_translator;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] mem_address = '0;
  logic        addr_valid = 1'b0;
  logic        mem_rw = 1'b0;
  logic [31:0] mem_new_address;
  logic        addr_resp;
  logic        cache_hit;
  logic        busy_o;
  logic        wrap_o;
  logic        range_err_o;

  int tests = 0;
  int fails = 0;

  // Reference model: page map, tag owners, allocation pointer, sticky flags
  int m_map [256];
  int m_tag [16];
  int m_free;
  bit m_wrap;
  bit m_rerr;

  ftl_addr_translator dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .mem_address     (mem_address),
    .addr_valid      (addr_valid),
    .mem_rw          (mem_rw),
    .mem_new_address (mem_new_address),
    .addr_resp       (addr_resp),
    .cache_hit       (cache_hit),
    .busy_o          (busy_o),
    .wrap_o          (wrap_o),
    .range_err_o     (range_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_map[i] = -1;
    for (int i = 0; i < 16; i++) m_tag[i] = -1;
    m_free = 0;
    m_wrap = 0;
    m_rerr = 0;
  endtask

  task automatic model_req(input logic [31:0] a, input logic rw,
                           output logic [31:0] ea, output logic eh, output int elat);
    int page, offs, idx;
    page = int'(a >> 12);
    offs = int'(a & 32'hFFF);
    if (a >= 32'h0010_0000) begin
      ea = a; eh = 0; elat = 2; m_rerr = 1;
      return;
    end
    idx = page % 16;
    eh  = (m_tag[idx] == page);
    m_tag[idx] = page;
    if (rw) begin
      ea = 32'(m_free * 4096 + offs);
      m_map[page] = m_free;
      m_free = (m_free + 1) % 512;
      if (m_free == 0) m_wrap = 1;
      elat = 3;
    end else begin
      ea = (m_map[page] >= 0) ? 32'(m_map[page] * 4096 + offs) : a;
      elat = 2;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    addr_valid = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // 4-phase master; lat counts edges after the one that samples valid
  task automatic do_req(input logic [31:0] a, input logic rw,
                        output logic [31:0] na, output logic h, output int lat);
    int n;
    @(negedge clk_i);
    mem_address = a;
    mem_rw      = rw;
    addr_valid  = 1'b1;
    n = 0;
    do begin
      @(posedge clk_i); #1; n++;
    end while (!addr_resp && n < 20);
    lat = n - 1;
    na  = mem_new_address;
    h   = cache_hit;
    @(negedge clk_i);
    addr_valid = 1'b0;
    n = 0;
    while (addr_resp && n < 20) begin
      @(posedge clk_i); #1; n++;
    end
    tests++;
    if (addr_resp !== 1'b0) begin
      fails++;
      $display("FAIL resp_release: addr_resp=%b required 0", addr_resp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] na; logic h; int lat;
    do_reset();
    #1;
    tests++;
    if ({addr_resp, cache_hit, busy_o, wrap_o, range_err_o} !== 5'b0 || mem_new_address !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: resp/hit/busy/wrap/rerr=%b addr=%h required 00000 00000000",
               {addr_resp, cache_hit, busy_o, wrap_o, range_err_o}, mem_new_address);
    end
    do_req(32'h0000_3040, 1'b0, na, h, lat);
    tests++;
    if (na !== 32'h0000_3040 || h !== 1'b0) begin
      fails++;
      $display("FAIL first_read: addr=%h hit=%b required 00003040 0", na, h);
    end
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL read_latency: got %0d required 2", lat);
    end
  endtask

  task automatic test_write_alloc();
    logic [31:0] ra [3] = '{32'h0000_5010, 32'h0000_5020, 32'h0000_5010};
    logic        rw [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] ea [3] = '{32'h0000_0010, 32'h0000_0020, 32'h0000_1010};
    logic        eh [3] = '{1'b0, 1'b1, 1'b1};
    int          el [3] = '{3, 2, 3};
    logic [31:0] na; logic h; int lat;
    for (int i = 0; i < 3; i++) begin
      do_req(ra[i], rw[i], na, h, lat);
      tests++;
      if (na !== ea[i] || h !== eh[i] || lat !== el[i]) begin
        fails++;
        $display("FAIL write_alloc[%0d]: addr=%h hit=%b lat=%0d required %h %b %0d",
                 i, na, h, lat, ea[i], eh[i], el[i]);
      end
    end
  endtask

  task automatic test_evict();
    logic [31:0] na; logic h; int lat;
    do_req(32'h0001_5000, 1'b1, na, h, lat);
    tests++;
    if (na !== 32'h0000_2000 || h !== 1'b0) begin
      fails++;
      $display("FAIL evict_write: addr=%h hit=%b required 00002000 0", na, h);
    end
    do_req(32'h0000_5000, 1'b0, na, h, lat);
    tests++;
    if (na !== 32'h0000_1000 || h !== 1'b0) begin
      fails++;
      $display("FAIL evicted_read: addr=%h hit=%b required 00001000 0", na, h);
    end
  endtask

  task automatic test_range();
    logic [31:0] na; logic h; int lat;
    do_reset();
    do_req(32'h0010_0000, 1'b0, na, h, lat);
    tests++;
    if (na !== 32'h0010_0000 || h !== 1'b0 || range_err_o !== 1'b1) begin
      fails++;
      $display("FAIL range_read: addr=%h hit=%b rerr=%b required 00100000 0 1", na, h, range_err_o);
    end
    do_req(32'h0010_3040, 1'b1, na, h, lat);
    tests++;
    if (na !== 32'h0010_3040 || h !== 1'b0 || lat !== 2) begin
      fails++;
      $display("FAIL range_write: addr=%h hit=%b lat=%0d required 00103040 0 2", na, h, lat);
    end
    do_req(32'h0000_3040, 1'b0, na, h, lat);
    tests++;
    if (na !== 32'h0000_3040 || h !== 1'b0 || range_err_o !== 1'b1) begin
      fails++;
      $display("FAIL post_range_read: addr=%h hit=%b rerr=%b required 00003040 0 1", na, h, range_err_o);
    end
    do_req(32'h0000_3044, 1'b0, na, h, lat);
    tests++;
    if (na !== 32'h0000_3044 || h !== 1'b1) begin
      fails++;
      $display("FAIL read_allocate: addr=%h hit=%b required 00003044 1", na, h);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] na, ea; logic h; int lat;
    logic [31:0] off;
    do_reset();
    for (int i = 0; i < 512; i++) begin
      off = 32'($urandom_range(0, 4095));
      do_req(32'((i % 256) * 4096) | off, 1'b1, na, h, lat);
      ea = 32'(i * 4096) | off;
      tests++;
      if (na !== ea || wrap_o !== (i == 511)) begin
        fails++;
        $display("FAIL wrap_write[%0d]: addr=%h wrap=%b required %h %b", i, na, wrap_o, ea, (i == 511));
      end
    end
    do_req(32'h0000_7abc, 1'b1, na, h, lat);
    tests++;
    if (na !== 32'h0000_0abc || wrap_o !== 1'b1) begin
      fails++;
      $display("FAIL wrap_reuse: addr=%h wrap=%b required 00000abc 1", na, wrap_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] na; logic h; int lat;
    do_reset();
    @(negedge clk_i);
    mem_address = 32'h0000_9000;
    mem_rw      = 1'b1;
    addr_valid  = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    tests++;
    if (addr_resp !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: resp=%b busy=%b required 0 0", addr_resp, busy_o);
    end
    addr_valid = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    do_req(32'h0000_9000, 1'b0, na, h, lat);
    tests++;
    if (na !== 32'h0000_9000 || h !== 1'b0) begin
      fails++;
      $display("FAIL abort_read: addr=%h hit=%b required 00009000 0", na, h);
    end
    do_req(32'h0000_9abc, 1'b1, na, h, lat);
    tests++;
    if (na !== 32'h0000_0abc || h !== 1'b1) begin
      fails++;
      $display("FAIL abort_free_ptr: addr=%h hit=%b required 00000abc 1", na, h);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, na, ea; logic rw, h, eh; int lat, elat;
    do_reset();
    model_reset();
    for (int i = 0; i < 200; i++) begin
      a  = 32'($urandom_range(0, 40) * 4096 + $urandom_range(0, 4095));
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(20, 31));
      rw = 1'($urandom_range(0, 1));
      model_req(a, rw, ea, eh, elat);
      do_req(a, rw, na, h, lat);
      tests++;
      if (na !== ea || h !== eh || lat !== elat) begin
        fails++;
        $display("FAIL random[%0d] a=%h rw=%b: addr=%h hit=%b lat=%0d required %h %b %0d",
                 i, a, rw, na, h, lat, ea, eh, elat);
      end
    end
    tests++;
    if (range_err_o !== m_rerr || wrap_o !== m_wrap) begin
      fails++;
      $display("FAIL random_flags: rerr=%b wrap=%b required %b %b", range_err_o, wrap_o, m_rerr, m_wrap);
    end
  endtask

  initial begin
    test_reset();
    test_write_alloc();
    test_evict();
    test_range();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
